// File: rtl/hs_pkg.sv
// Shared types and default sizes for the clocked handshake sink.
package hs_pkg;

    // Handshake progress: waiting, committed but not yet acknowledged, acknowledged.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        ACK   = 2'd2
    } hs_state_t;

    localparam int HS_SYNC_STAGES = 2;
    localparam int HS_CNT_W       = 8;

    // Wide enough for the largest consumer latency (15).
    localparam int HS_DLY_W       = 4;

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer with synchronous active-high clear.
module sync_ff
    import hs_pkg::*;
#(
    parameter int N = HS_SYNC_STAGES
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [N-1:0] chain;

    // Shift the asynchronous input through N flops; clear empties the whole chain.
    always_ff @(posedge clk) begin
        if (clr) begin
            chain <= '0;
        end else begin
            chain <= {chain[N-2:0], d};
        end
    end

    assign q = chain[N-1];

endmodule

// File: rtl/hs_sink_sync.sv
// Clocked 4-phase handshake sink: synchronizes req_in, acknowledges after a
// programmable latency, counts completed tokens and flags early withdrawal.
module hs_sink_sync
    import hs_pkg::*;
#(
    parameter int SYNC_STAGES = HS_SYNC_STAGES,
    parameter int ACK_DELAY   = 0,
    parameter int CNT_W       = HS_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_in,
    output logic             ack_in,
    input  logic             enable,
    output logic             token_pulse,
    output logic [CNT_W-1:0] token_cnt,
    output logic             busy,
    output logic             err
);

    // The delay counter holds "extra cycles still to wait minus one", so the
    // cycle on which it reads zero is the last one spent in DELAY.
    localparam logic [HS_DLY_W-1:0] DLY_LOAD =
        (ACK_DELAY > 0) ? HS_DLY_W'(ACK_DELAY - 1) : '0;

    logic                req_s;
    hs_state_t           state;
    hs_state_t           state_nxt;
    logic [HS_DLY_W-1:0] dly_cnt;
    logic [HS_DLY_W-1:0] dly_nxt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                ack_nxt;
    logic                pulse_nxt;
    logic                busy_nxt;
    logic                err_nxt;

    sync_ff #(
        .N (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .clr (rst),
        .d   (req_in),
        .q   (req_s)
    );

    // Next-state decode; every output is derived from the next state so all outputs stay registered.
    always_comb begin
        state_nxt = state;
        dly_nxt   = dly_cnt;
        cnt_nxt   = token_cnt;
        err_nxt   = err;
        pulse_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (req_s && enable) begin
                    if (ACK_DELAY == 0) begin
                        state_nxt = ACK;
                    end else begin
                        state_nxt = DELAY;
                        dly_nxt   = DLY_LOAD;
                    end
                end
            end
            DELAY: begin
                if (!req_s) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                    dly_nxt   = '0;
                end else if (dly_cnt == '0) begin
                    state_nxt = ACK;
                end else begin
                    dly_nxt = dly_cnt - 1'b1;
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_nxt = IDLE;
                    pulse_nxt = 1'b1;
                    cnt_nxt   = token_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                dly_nxt   = '0;
            end
        endcase

        ack_nxt  = (state_nxt == ACK);
        busy_nxt = (state_nxt != IDLE);
    end

    // State, counters and output registers; reset abandons any handshake in flight without counting it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dly_cnt     <= '0;
            token_cnt   <= '0;
            ack_in      <= 1'b0;
            token_pulse <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            dly_cnt     <= dly_nxt;
            token_cnt   <= cnt_nxt;
            ack_in      <= ack_nxt;
            token_pulse <= pulse_nxt;
            busy        <= busy_nxt;
            err         <= err_nxt;
        end
    end

endmodule

// File: tb/tb_hs_sink_sync.sv
// Self-checking bench for hs_sink_sync: four instances with different
// latency / counter width, a cycle model, and directed scenarios.
module tb_hs_sink_sync;

    localparam int NI = 4;
    localparam int DLY [NI] = '{0, 4, 5, 0};
    localparam int CW  [NI] = '{8, 8, 8, 3};
    localparam int SYNC = 2;

    logic clk;
    logic rst;
    logic req   [NI];
    logic en    [NI];
    logic ack   [NI];
    logic pulse [NI];
    logic busy  [NI];
    logic err   [NI];
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic [7:0] cnt2;
    logic [2:0] cnt3;

    int checkCount;
    int errorCount;
    bit modelValid;

    // Model state: last SYNC req samples, handshake phase (0 waiting,
    // 1 committed, 2 acknowledged), cycles left before ack, tokens seen.
    logic [3:0] mHist   [NI];
    int         mPhase  [NI];
    int         mRemain [NI];
    int         mTokens [NI];
    bit         mErr    [NI];
    bit         mPulse  [NI];

    hs_sink_sync #(.SYNC_STAGES(SYNC), .ACK_DELAY(DLY[0]), .CNT_W(CW[0])) u0 (
        .clk(clk), .rst(rst), .req_in(req[0]), .ack_in(ack[0]), .enable(en[0]),
        .token_pulse(pulse[0]), .token_cnt(cnt0), .busy(busy[0]), .err(err[0]));
    hs_sink_sync #(.SYNC_STAGES(SYNC), .ACK_DELAY(DLY[1]), .CNT_W(CW[1])) u1 (
        .clk(clk), .rst(rst), .req_in(req[1]), .ack_in(ack[1]), .enable(en[1]),
        .token_pulse(pulse[1]), .token_cnt(cnt1), .busy(busy[1]), .err(err[1]));
    hs_sink_sync #(.SYNC_STAGES(SYNC), .ACK_DELAY(DLY[2]), .CNT_W(CW[2])) u2 (
        .clk(clk), .rst(rst), .req_in(req[2]), .ack_in(ack[2]), .enable(en[2]),
        .token_pulse(pulse[2]), .token_cnt(cnt2), .busy(busy[2]), .err(err[2]));
    hs_sink_sync #(.SYNC_STAGES(SYNC), .ACK_DELAY(DLY[3]), .CNT_W(CW[3])) u3 (
        .clk(clk), .rst(rst), .req_in(req[3]), .ack_in(ack[3]), .enable(en[3]),
        .token_pulse(pulse[3]), .token_cnt(cnt3), .busy(busy[3]), .err(err[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int getCnt(input int i);
        case (i)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            2:       return int'(cnt2);
            default: return int'(cnt3);
        endcase
    endfunction

    // One clock edge of the protocol as described: the synchronized request
    // is the raw request SYNC edges old; ack comes DLY edges after commit.
    function automatic void modelStep(input int i);
        bit reqS;
        if (rst) begin
            mHist[i]   = '0;
            mPhase[i]  = 0;
            mRemain[i] = 0;
            mTokens[i] = 0;
            mErr[i]    = 1'b0;
            mPulse[i]  = 1'b0;
            return;
        end
        reqS      = mHist[i][SYNC-1];
        mHist[i]  = {mHist[i][2:0], req[i]};
        mPulse[i] = 1'b0;
        if (mPhase[i] == 0) begin
            if (reqS && en[i]) begin
                mPhase[i]  = (DLY[i] == 0) ? 2 : 1;
                mRemain[i] = DLY[i];
            end
        end else if (mPhase[i] == 1) begin
            if (!reqS) begin
                mErr[i]   = 1'b1;
                mPhase[i] = 0;
            end else begin
                mRemain[i] = mRemain[i] - 1;
                if (mRemain[i] == 0) mPhase[i] = 2;
            end
        end else begin
            if (!reqS) begin
                mPhase[i]  = 0;
                mPulse[i]  = 1'b1;
                mTokens[i] = (mTokens[i] + 1) % (1 << CW[i]);
            end
        end
    endfunction

    // Advance the model on every active edge.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) modelStep(i);
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int i, input logic r, input logic e);
        req[i] = r;
        en[i]  = e;
    endtask

    // Wait for ack of instance i to reach target; returns edges taken or -1.
    task automatic measureAck(input int i, input logic target, output int edges);
        edges = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (ack[i] === target) begin
                edges = n;
                break;
            end
        end
    endtask

    // Every cycle, all outputs of every instance against the model.
    always @(negedge clk) begin
        if (modelValid) begin
            for (int i = 0; i < NI; i++) begin
                checkOutput($sformatf("u%0d ack", i),   int'(ack[i]),   (mPhase[i] == 2) ? 1 : 0);
                checkOutput($sformatf("u%0d busy", i),  int'(busy[i]),  (mPhase[i] != 0) ? 1 : 0);
                checkOutput($sformatf("u%0d pulse", i), int'(pulse[i]), int'(mPulse[i]));
                checkOutput($sformatf("u%0d err", i),   int'(err[i]),   int'(mErr[i]));
                checkOutput($sformatf("u%0d cnt", i),   getCnt(i),      mTokens[i]);
            end
        end
    end

    initial begin
        int edges;
        int pulsesSeen;
        bit sawAck;
        bit sawBusy;
        int wrapExp [9];
        wrapExp = '{1, 2, 3, 4, 5, 6, 7, 0, 1};

        checkCount = 0;
        errorCount = 0;
        modelValid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < NI; i++) applyStimulus(i, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("reset ack", int'(ack[0]), 0);
        checkOutput("reset busy", int'(busy[0]), 0);
        checkOutput("reset cnt", getCnt(0), 0);
        checkOutput("reset err", int'(err[0]), 0);
        rst = 1'b0;
        modelValid = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] basic handshake");
        applyStimulus(0, 1'b1, 1'b1);
        measureAck(0, 1'b1, edges);
        checkOutput("basic rise latency", edges, 3);
        applyStimulus(0, 1'b0, 1'b1);
        measureAck(0, 1'b0, edges);
        checkOutput("basic fall latency", edges, 3);
        checkOutput("basic pulse", int'(pulse[0]), 1);
        checkOutput("basic cnt", getCnt(0), 1);
        @(negedge clk);
        checkOutput("basic pulse width", int'(pulse[0]), 0);

        $display("[TB] consumer latency");
        applyStimulus(1, 1'b1, 1'b1);
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            checkOutput($sformatf("latency busy e%0d", e), int'(busy[1]), (e >= 3) ? 1 : 0);
            checkOutput($sformatf("latency ack e%0d", e), int'(ack[1]), (e == 7) ? 1 : 0);
        end
        applyStimulus(1, 1'b0, 1'b1);
        measureAck(1, 1'b0, edges);
        checkOutput("latency fall", edges, 3);
        checkOutput("latency cnt", getCnt(1), 1);

        $display("[TB] back-pressure");
        applyStimulus(0, 1'b1, 1'b0);
        sawAck = 1'b0;
        sawBusy = 1'b0;
        repeat (20) begin
            @(negedge clk);
            sawAck  |= ack[0];
            sawBusy |= busy[0];
        end
        checkOutput("bp ack held low", int'(sawAck), 0);
        checkOutput("bp busy held low", int'(sawBusy), 0);
        applyStimulus(0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("bp ack after enable", int'(ack[0]), 1);
        applyStimulus(0, 1'b0, 1'b1);
        measureAck(0, 1'b0, edges);
        checkOutput("bp fall", edges, 3);
        checkOutput("bp cnt", getCnt(0), 2);

        $display("[TB] protocol violation");
        applyStimulus(2, 1'b1, 1'b1);
        sawAck = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n == 4) applyStimulus(2, 1'b0, 1'b1);
            sawAck |= ack[2];
        end
        checkOutput("viol ack never", int'(sawAck), 0);
        checkOutput("viol err", int'(err[2]), 1);
        checkOutput("viol cnt", getCnt(2), 0);
        checkOutput("viol busy", int'(busy[2]), 0);
        repeat (5) @(negedge clk);
        checkOutput("viol err sticky", int'(err[2]), 1);

        $display("[TB] counter wrap");
        pulsesSeen = 0;
        for (int h = 0; h < 9; h++) begin
            applyStimulus(3, 1'b1, 1'b1);
            measureAck(3, 1'b1, edges);
            checkOutput($sformatf("wrap%0d rise", h), edges, 3);
            applyStimulus(3, 1'b0, 1'b1);
            measureAck(3, 1'b0, edges);
            checkOutput($sformatf("wrap%0d fall", h), edges, 3);
            if (pulse[3]) pulsesSeen++;
            checkOutput($sformatf("wrap%0d cnt", h), getCnt(3), wrapExp[h]);
        end
        checkOutput("wrap pulses", pulsesSeen, 9);

        $display("[TB] reset mid-handshake");
        applyStimulus(0, 1'b1, 1'b1);
        measureAck(0, 1'b1, edges);
        checkOutput("rmid rise", edges, 3);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rmid ack", int'(ack[0]), 0);
        checkOutput("rmid cnt", getCnt(0), 0);
        checkOutput("rmid busy", int'(busy[0]), 0);
        rst = 1'b0;
        measureAck(0, 1'b1, edges);
        checkOutput("rmid re-rise", edges, 3);
        applyStimulus(0, 1'b0, 1'b1);
        measureAck(0, 1'b0, edges);
        checkOutput("rmid fall", edges, 3);
        checkOutput("rmid cnt after", getCnt(0), 1);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
